// File: rtl/temp_uart_pkg.sv
// Shared constants for the temperature UART reporter: ASCII codes, FSM states, frame length.
// Frame length depends on TEMP_UART_FRAC_EN (adds '.' and the tenth digit).
package temp_uart_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

`ifdef TEMP_UART_FRAC_EN
  localparam int unsigned FRAME_LEN = 8;
`else
  localparam int unsigned FRAME_LEN = 6;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; done pulses during the final cycle of the stop bit so the
// caller can launch the next byte exactly one idle cycle after the stop bit.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          active_q, active_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        tx_d     = 1'b0;
        shift_d  = {1'b1, data};
        baud_d   = '0;
        bit_d    = '0;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_d = baud_q + CW'(1);
    end
    // Registered pulse lands on the last cycle of the stop bit.
    done_d = active_d && (bit_d == 4'd9) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;

endmodule

// File: rtl/temp_uart_report.sv
// Snapshots the DS18B20 raw word on a periodic or requested trigger and sends it as
// signed decimal ASCII over UART. TEMP_UART_FRAC_EN adds the ".d" tenth digit.
module temp_uart_report #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned REPORT_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temperature,
  input  logic        send_req,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done
);

  import temp_uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned PERIOD       = REPORT_MS * (CLK_FREQ / 1000);
  localparam logic [31:0] PER_LAST     = (PERIOD == 0) ? 32'd0 : 32'(PERIOD - 1);
  localparam logic [2:0]  IDX_LAST     = 3'(FRAME_LEN - 1);

  state_t      state_q;
  logic [31:0] per_q;
  logic [2:0]  idx_q;
  logic [15:0] snap_q;
  logic        neg_q;
  logic [3:0]  hund_q, tens_q, unit_q;
  logic        busy_q, frame_done_q;

  logic        period_hit, tx_start, byte_done;
  logic [7:0]  tx_byte;
  logic [15:0] mag_d;
  logic [6:0]  int_d;

  assign period_hit = (PERIOD != 0) && (per_q == PER_LAST);
  assign tx_start   = (state_q == ST_SEND);

  assign mag_d = snap_q[15] ? (~snap_q + 16'd1) : snap_q;
  assign int_d = mag_d[10:4];

`ifdef TEMP_UART_FRAC_EN
  logic [3:0] tenth_q;
  logic [7:0] frac_x10_d;
  logic       unused_mag;
  assign frac_x10_d = {4'b0, mag_d[3:0]} * 8'd10;
  assign unused_mag = ^{mag_d[15:11], frac_x10_d[3:0]};
`else
  logic unused_mag;
  assign unused_mag = ^{mag_d[15:11], mag_d[3:0]};
`endif

  always_comb begin
    tx_byte = ASCII_LF;
    case (idx_q)
      3'd0: tx_byte = neg_q ? ASCII_MINUS : ASCII_PLUS;
      3'd1: tx_byte = ASCII_ZERO + {4'b0, hund_q};
      3'd2: tx_byte = ASCII_ZERO + {4'b0, tens_q};
      3'd3: tx_byte = ASCII_ZERO + {4'b0, unit_q};
`ifdef TEMP_UART_FRAC_EN
      3'd4: tx_byte = ASCII_DOT;
      3'd5: tx_byte = ASCII_ZERO + {4'b0, tenth_q};
      3'd6: tx_byte = ASCII_CR;
`else
      3'd4: tx_byte = ASCII_CR;
`endif
      default: tx_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      per_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      neg_q        <= 1'b0;
      hund_q       <= '0;
      tens_q       <= '0;
      unit_q       <= '0;
`ifdef TEMP_UART_FRAC_EN
      tenth_q      <= '0;
`endif
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      per_q        <= period_hit ? '0 : per_q + 32'd1;
      case (state_q)
        ST_IDLE: begin
          if (send_req || period_hit) begin
            snap_q  <= temperature;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          neg_q   <= snap_q[15];
          hund_q  <= 4'(int_d / 7'd100);
          tens_q  <= 4'((int_d / 7'd10) % 7'd10);
          unit_q  <= 4'(int_d % 7'd10);
`ifdef TEMP_UART_FRAC_EN
          tenth_q <= frac_x10_d[7:4];
`endif
          idx_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          busy_q  <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (byte_done) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_byte),
    .tx    (uart_tx),
    .done  (byte_done)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_temp_uart_report.sv
// Bench for temp_uart_report: cycle-exact waveform model from the frame timing rules,
// a UART receiver for literal frame checks, then randomized triggers/temps/resets.
module tb_temp_uart_report;

  localparam int C  = 10;     // 1 MHz / 100 kBd
  localparam int P  = 1000;   // 1 ms at 1 MHz
`ifdef TEMP_UART_FRAC_EN
  localparam int NB = 8;
  localparam logic [63:0] F0191 = 64'h2B3032352E300D0A;
  localparam logic [63:0] FFF5E = 64'h2D3031302E310D0A;
  localparam logic [63:0] F07D0 = 64'h2B3132352E300D0A;
  localparam logic [63:0] F0000 = 64'h2B3030302E300D0A;
  localparam logic [63:0] FFC90 = 64'h2D3035352E300D0A;
  localparam logic [63:0] F0198 = 64'h2B3032352E350D0A;
`else
  localparam int NB = 6;
  localparam logic [63:0] F0191 = 64'h2B3032350D0A;
  localparam logic [63:0] FFF5E = 64'h2D3031300D0A;
  localparam logic [63:0] F07D0 = 64'h2B3132350D0A;
  localparam logic [63:0] F0000 = 64'h2B3030300D0A;
  localparam logic [63:0] FFC90 = 64'h2D3035350D0A;
  localparam logic [63:0] F0198 = 64'h2B3032350D0A;
`endif
  localparam int L = NB * (10 * C + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [15:0] temperature = '0;
  logic        uart_tx, busy, frame_done;

  temp_uart_report #(.CLK_FREQ(1_000_000), .BAUD(100_000), .REPORT_MS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .send_req    (send_req),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ref_byte(input logic [15:0] t, input int i);
    int mag, ip;
    int seq[8];
    mag = t[15] ? (65536 - int'(t)) : int'(t);
    ip  = (mag / 16) % 128;
    seq[0] = t[15] ? 45 : 43;
    seq[1] = 48 + ip / 100;
    seq[2] = 48 + (ip / 10) % 10;
    seq[3] = 48 + ip % 10;
`ifdef TEMP_UART_FRAC_EN
    seq[4] = 46;
    seq[5] = 48 + ((mag % 16) * 10) / 16;
    seq[6] = 13;
    seq[7] = 10;
`else
    seq[4] = 13;
    seq[5] = 10;
    seq[6] = 0;
    seq[7] = 0;
`endif
    return 8'(seq[i]);
  endfunction

  // o = cycles since the first start bit began
  function automatic logic exp_tx(input logic [15:0] t, input int o);
    int i, r, b;
    logic [7:0] v;
    i = o / (10 * C + 1);
    r = o % (10 * C + 1);
    if (r >= 10 * C) return 1'b1;
    b = r / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    v = ref_byte(t, i);
    return v[b-1];
  endfunction

  // Reference model: advanced on each rising edge from the inputs only.
  longint      edge_n = 0;
  int          pcnt = 0;
  bit          fr_act = 0;
  longint      fr_start = 0;
  logic [15:0] fr_temp = '0;

  always @(posedge clk) begin
    bit hit;
    edge_n++;
    if (rst) begin
      fr_act = 0;
      pcnt   = 0;
    end else begin
      hit  = (pcnt == P - 1);
      pcnt = hit ? 0 : pcnt + 1;
      if ((send_req || hit) && (!fr_act || edge_n >= fr_start + L + 3)) begin
        fr_act   = 1;
        fr_start = edge_n;
        fr_temp  = temperature;
      end
    end
  end

  // Per-cycle compare plus UART receiver, sampled on the falling edge.
  bit         rx_act = 0;
  int         rx_t = 0;
  logic [7:0] rx_sh = '0;
  logic       prev_tx = 1'b1;
  logic [7:0] rxq[$];
  int         fd_cnt = 0;

  always @(negedge clk) begin
    longint off;
    logic etx, ebusy, edone;
    off   = fr_act ? (edge_n - fr_start) : -1;
    etx   = 1'b1;
    ebusy = 1'b0;
    if (off >= 2 && off < 2 + L) begin
      ebusy = 1'b1;
      etx   = exp_tx(fr_temp, int'(off - 2));
    end
    edone = (off == 2 + L);
    checks++;
    if ({uart_tx, busy, frame_done} !== {etx, ebusy, edone}) begin
      errors++;
      if (errors < 20)
        $display("FAIL cycle %0d tx/busy/done: got %b%b%b want %b%b%b",
                 edge_n, uart_tx, busy, frame_done, etx, ebusy, edone);
    end
    if (frame_done) fd_cnt++;
    if (rst) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (prev_tx && !uart_tx) begin
        rx_act = 1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % C == C / 2 && rx_t / C >= 1 && rx_t / C <= 8) rx_sh = {uart_tx, rx_sh[7:1]};
      if (rx_t == 9 * C + C / 2) begin
        rxq.push_back(rx_sh);
        rx_act = 0;
      end
    end
    prev_tx = uart_tx;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] t);
    temperature = t;
    send_req = 1'b1;
    cyc(1);
    send_req = 1'b0;
  endtask

  task automatic start_latency(output int k);
    k = 0;
    while (uart_tx && k < 10) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < L + 50 && !ok; i++) begin
      cyc(1);
      if (frame_done) ok = 1;
    end
    chk({nm, "_frame_done_seen"}, ok, 1);
  endtask

  task automatic check_frame(input string nm, input logic [63:0] want);
    logic [63:0] got;
    got = '0;
    foreach (rxq[i]) got = {got[55:0], rxq[i]};
    checks++;
    if (rxq.size() != NB || got !== want) begin
      errors++;
      $display("FAIL %s: got %h (%0d bytes) want %h", nm, got, rxq.size(), want);
    end
    rxq.delete();
  endtask

  initial begin
    int k, w;
    longint s1, s2;

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("reset_tx", uart_tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    cyc(2);

    // Positive value, latency, start-bit width, input change mid-frame
    rxq.delete();
    fd_cnt = 0;
    send(16'h0191);
    start_latency(k);
    chk("start_latency", k, 2);
    chk("busy_at_start", busy, 1);
    w = 0;
    while (!uart_tx && w < 50) begin
      cyc(1);
      w++;
    end
    chk("start_bit_width", w, C);
    temperature = 16'h1234;
    wait_done("pos");
    check_frame("frame_0191", F0191);
    chk("frame_done_once", fd_cnt, 1);

    // Negative value
    do_reset();
    send(16'hFF5E);
    wait_done("neg");
    check_frame("frame_FF5E", FFF5E);

    // Upper limit, with a request while busy that must be dropped
    do_reset();
    fd_cnt = 0;
    send(16'h07D0);
    cyc(200);
    send(16'h0000);
    wait_done("max");
    check_frame("frame_07D0", F07D0);
    cyc(30);
    chk("dropped_req_bytes", rxq.size(), 0);
    chk("dropped_req_busy", busy, 0);
    chk("dropped_req_frame_done", fd_cnt, 1);

    // Zero, then a request in the frame_done cycle
    do_reset();
    send(16'h0000);
    wait_done("zero");
    chk("fd_cycle_busy_low", busy, 0);
    send(16'hFC90);
    check_frame("frame_0000", F0000);
    start_latency(k);
    chk("fd_cycle_latency", k, 2);
    wait_done("min");
    check_frame("frame_FC90", FFC90);

    // Reset mid-byte
    do_reset();
    send(16'h0191);
    cyc(150);
    rst = 1'b1;
    cyc(1);
    chk("midreset_tx", uart_tx, 1);
    chk("midreset_busy", busy, 0);
    rst = 1'b0;
    rxq.delete();

    // Periodic reporting
    do_reset();
    temperature = 16'h0198;
    k = 0;
    while (!busy && k < 1100) begin
      cyc(1);
      k++;
    end
    s1 = edge_n;
    wait_done("periodic");
    check_frame("frame_periodic_0198", F0198);
    k = 0;
    while (!busy && k < 1100) begin
      cyc(1);
      k++;
    end
    s2 = edge_n;
    chk("periodic_interval", s2 - s1, P);
    wait_done("periodic2");
    rxq.delete();

    // Randomized triggers, temperatures and occasional resets
    for (int i = 0; i < 20000; i++) begin
      send_req = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) temperature = 16'($urandom);
      rst = ($urandom_range(0, 3999) == 0);
      cyc(1);
    end
    send_req = 1'b0;
    rst = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
